// File: rtl/demux_select_sequencer.sv
// Select sequencer for the 1-to-4 LED demux: debounces two switches into press
// events and steps the channel index manually or by an automatic up/down scan.
//
// state     | meaning
// MANUAL    | switch 2 steps idx +1, step counter held at 0
// AUTO_UP   | idx +1 every STEP_LIMIT+1 cycles, switch 2 pauses/resumes
// AUTO_DOWN | idx -1 every STEP_LIMIT+1 cycles, switch 2 pauses/resumes
module demux_select_sequencer #(
  parameter int DEBOUNCE_LIMIT = 249999,
  parameter int STEP_LIMIT     = 4194303
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_switch_1,
  input  logic       i_switch_2,
  output logic       o_sel0,
  output logic       o_sel1,
  output logic [1:0] o_mode,
  output logic       o_paused,
  output logic       o_step
);

  localparam int DB_W = (DEBOUNCE_LIMIT > 0) ? $clog2(DEBOUNCE_LIMIT + 1) : 1;
  localparam int ST_W = (STEP_LIMIT > 0) ? $clog2(STEP_LIMIT + 1) : 1;
  localparam logic [DB_W-1:0] DB_LIM = DB_W'(DEBOUNCE_LIMIT);
  localparam logic [ST_W-1:0] ST_LIM = ST_W'(STEP_LIMIT);

  typedef enum logic [1:0] {
    MANUAL    = 2'b00,
    AUTO_UP   = 2'b01,
    AUTO_DOWN = 2'b10
  } mode_e;

  logic [1:0]      raw;
  logic [1:0]      sync_a;
  logic [1:0]      sync_b;
  logic [1:0]      accepted;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  mode_e           state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic            paused_q, paused_d;
  logic [ST_W-1:0] step_cnt_q, step_cnt_d;
  logic            step_q, step_d;

  assign raw = {i_switch_2, i_switch_1};

  // Index 0 is switch 1 (mode), index 1 is switch 2 (step/pause).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_a   <= '0;
      sync_b   <= '0;
      accepted <= '0;
      press    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == accepted[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LIM) begin
          accepted[i] <= sync_b[i];
          db_cnt[i]   <= '0;
          press[i]    <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= MANUAL;
      idx_q      <= '0;
      paused_q   <= 1'b0;
      step_cnt_q <= '0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      paused_q   <= paused_d;
      step_cnt_q <= step_cnt_d;
      step_q     <= step_d;
    end
  end

  // A mode press wins over a simultaneous step press or auto step.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    paused_d   = paused_q;
    step_cnt_d = step_cnt_q;
    step_d     = 1'b0;
    if (press[0]) begin
      paused_d   = 1'b0;
      step_cnt_d = '0;
      case (state_q)
        MANUAL:  state_d = AUTO_UP;
        AUTO_UP: state_d = AUTO_DOWN;
        default: state_d = MANUAL;
      endcase
    end else begin
      case (state_q)
        MANUAL: begin
          step_cnt_d = '0;
          if (press[1]) begin
            idx_d  = idx_q + 2'd1;
            step_d = 1'b1;
          end
        end
        AUTO_UP, AUTO_DOWN: begin
          if (press[1]) begin
            paused_d = ~paused_q;
          end else if (!paused_q) begin
            if (step_cnt_q == ST_LIM) begin
              step_cnt_d = '0;
              idx_d      = (state_q == AUTO_UP) ? idx_q + 2'd1 : idx_q - 2'd1;
              step_d     = 1'b1;
            end else begin
              step_cnt_d = step_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d    = MANUAL;
          paused_d   = 1'b0;
          step_cnt_d = '0;
        end
      endcase
    end
  end

  assign o_sel0   = idx_q[0];
  assign o_sel1   = idx_q[1];
  assign o_mode   = state_q;
  assign o_paused = paused_q;
  assign o_step   = step_q;

endmodule

// File: tb/tb_demux_select_sequencer.sv
// Bench for demux_select_sequencer: directed scenarios plus random switch
// activity, every cycle compared against an event-level reference model.
module tb_demux_select_sequencer;

  localparam int DL = 3;
  localparam int SL = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic       sel0, sel1, paused, step;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_bad = 0;
  int steps_seen = 0;

  // reference model state
  int m_s1 [2];
  int m_s2 [2];
  int m_acc [2];
  int m_run [2];
  int m_press [2];
  int m_mode, m_idx, m_paused, m_phase, m_step;

  demux_select_sequencer #(.DEBOUNCE_LIMIT(DL), .STEP_LIMIT(SL)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_switch_1 (sw1),
    .i_switch_2 (sw2),
    .o_sel0     (sel0),
    .o_sel1     (sel1),
    .o_mode     (mode),
    .o_paused   (paused),
    .o_step     (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_acc[i] = 0; m_run[i] = 0; m_press[i] = 0;
    end
    m_mode = 0; m_idx = 0; m_paused = 0; m_phase = 0; m_step = 0;
  endtask

  // One rising edge: control reacts to last edge's press events, then the
  // switch pipeline advances.
  task automatic model_step(input int r1, input int r2);
    int raw [2];
    int np [2];
    raw[0] = r1; raw[1] = r2;
    m_step = 0;
    if (m_press[0] != 0) begin
      m_mode = (m_mode + 1) % 3;
      m_paused = 0;
      m_phase = 0;
    end else if (m_mode == 0) begin
      m_phase = 0;
      if (m_press[1] != 0) begin
        m_idx = (m_idx + 1) % 4;
        m_step = 1;
      end
    end else if (m_press[1] != 0) begin
      m_paused = (m_paused == 0) ? 1 : 0;
    end else if (m_paused == 0) begin
      m_phase++;
      if (m_phase == SL + 1) begin
        m_phase = 0;
        m_idx = (m_idx + ((m_mode == 1) ? 1 : 3)) % 4;
        m_step = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      np[i] = 0;
      if (m_s2[i] != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == DL + 1) begin
          m_acc[i] = m_s2[i];
          m_run[i] = 0;
          np[i] = m_acc[i];
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
      m_press[i] = np[i];
    end
  endtask

  task automatic check_outputs();
    chk("idx", int'({sel1, sel0}), m_idx);
    chk("mode", int'(mode), m_mode);
    chk("paused", int'(paused), m_paused);
    chk("step", int'(step), m_step);
    if (step) steps_seen++;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (rst_n) model_step(int'(sw1), int'(sw2));
    @(negedge clk);
    check_outputs();
  endtask

  task automatic hold(input int s1, input int s2, input int n);
    sw1 = s1[0];
    sw2 = s2[0];
    repeat (n) run_cycle();
  endtask

  task automatic async_reset_check();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_idx", int'({sel1, sel0}), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_paused", int'(paused), 0);
    chk("rst_step", int'(step), 0);
  endtask

  initial begin
    int start_idx;
    model_reset();
    // reset held
    hold(0, 0, 3);
    chk("reset_idx", int'({sel1, sel0}), 0);
    chk("reset_mode", int'(mode), 0);
    rst_n = 1'b1;
    hold(0, 0, 4);

    // debounce: short pulse rejected, long hold accepted once
    hold(0, 1, 3);
    hold(0, 0, 10);
    chk("glitch_idx", int'({sel1, sel0}), 0);
    steps_seen = 0;
    hold(0, 1, 12);
    hold(0, 0, 12);
    chk("debounced_idx", int'({sel1, sel0}), 1);
    chk("debounced_steps", steps_seen, 1);

    // manual wrap: four presses
    start_idx = m_idx;
    steps_seen = 0;
    for (int k = 0; k < 4; k++) begin
      hold(0, 1, 8);
      hold(0, 0, 8);
      chk("wrap_idx", int'({sel1, sel0}), (start_idx + k + 1) % 4);
    end
    chk("wrap_steps", steps_seen, 4);

    // auto up
    hold(1, 0, 8);
    hold(0, 0, 40);
    chk("auto_up_mode", int'(mode), 1);

    // auto down with pause / resume
    hold(1, 0, 8);
    hold(0, 0, 20);
    chk("auto_down_mode", int'(mode), 2);
    hold(0, 1, 8);
    hold(0, 0, 30);
    chk("paused_flag", int'(paused), 1);
    hold(0, 1, 8);
    hold(0, 0, 20);

    // back to manual, walk to idx 2, then press both together
    hold(1, 0, 8);
    hold(0, 0, 4);
    chk("manual_mode", int'(mode), 0);
    for (int k = 0; k < 4 && m_idx != 2; k++) begin
      hold(0, 1, 8);
      hold(0, 0, 8);
    end
    chk("pre_both_idx", int'({sel1, sel0}), 2);
    hold(1, 1, 6);
    hold(0, 0, 1);
    chk("both_mode", int'(mode), 1);
    chk("both_idx", int'({sel1, sel0}), 2);

    // abort auto scan with async reset mid-count
    hold(0, 0, 4);
    async_reset_check();
    hold(0, 0, 2);
    rst_n = 1'b1;
    hold(0, 0, 20);
    chk("post_abort_idx", int'({sel1, sel0}), 0);
    chk("post_abort_mode", int'(mode), 0);

    // random switch activity with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 40) == 0) begin
        async_reset_check();
        hold(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end else begin
        hold(($urandom_range(0, 5) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
             int'($urandom_range(1, 12)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_select_sequencer.md
# demux_select_sequencer

Generates the 2-bit select for the 1-to-4 LED demux so the blinking toggle can be routed to one LED at a time, either stepped by hand or scanned automatically. Both board switches are synchronised, debounced and turned into single-cycle press events. Switch 1 cycles the operating mode. Switch 2 steps the channel in manual mode and pauses/resumes scanning in the automatic modes. The block sits between the raw switch pins and the demux select inputs, in the same clock domain as the toggle counter.

## Interface
- DEBOUNCE_LIMIT, 249999: a synchronised switch level must differ from the accepted level for DEBOUNCE_LIMIT+1 consecutive edges before it is accepted.
- STEP_LIMIT, 4194303: in auto mode the channel advances once every STEP_LIMIT+1 cycles.
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_switch_1  in  1  raw mode switch, active high, asynchronous to i_clk.
- i_switch_2  in  1  raw step/pause switch, active high, asynchronous to i_clk.
- o_sel0  out  1  channel index bit 0, to demux i_sel0.
- o_sel1  out  1  channel index bit 1, to demux i_sel1.
- o_mode  out  2  00 MANUAL, 01 AUTO_UP, 10 AUTO_DOWN; 11 is never driven.
- o_paused  out  1  high while auto scanning is paused.
- o_step  out  1  one-cycle pulse in the cycle the channel index changes.

## Operation
- Per switch: 2-flop synchroniser, then a debounce counter (width $clog2(DEBOUNCE_LIMIT+1)). On each edge:
  - sync output equals accepted level: counter is cleared.
  - sync output differs and counter < DEBOUNCE_LIMIT: counter increments.
  - sync output differs and counter == DEBOUNCE_LIMIT: accepted level takes the sync value and the counter clears.
- A press is a registered one-cycle pulse, asserted in the cycle the accepted level goes 0->1. A 1->0 transition produces no event.
- The channel index idx is 2 bits; o_sel1:o_sel0 = idx. All idx arithmetic is modulo 4.
- Mode FSM, advanced by press1: MANUAL -> AUTO_UP -> AUTO_DOWN -> MANUAL.
- On any mode change: clear paused, clear the step counter, leave idx unchanged.
- MANUAL: press2 sets idx to idx+1 (3 wraps to 0). The step counter is held at 0.
- AUTO_UP / AUTO_DOWN, not paused:
  - Step counter (width $clog2(STEP_LIMIT+1)) increments each cycle.
  - At STEP_LIMIT it wraps to 0 and idx goes +1 (AUTO_UP) or -1 (AUTO_DOWN; 0 wraps to 3).
- AUTO_UP / AUTO_DOWN, press2 toggles paused. While paused, the step counter and idx hold their values. On resume, counting continues from the held count.
- press1 and press2 in the same cycle: press1 is acted on and press2 is discarded.
- o_step is a registered pulse asserted exactly when idx changes, for both manual and auto changes.

## Timing
- Reset (asynchronous, immediate): idx=0, o_sel0=o_sel1=0, o_mode=00, o_paused=0, o_step=0. Synchronisers, accepted levels, press registers and all counters are cleared.
- Assertion of i_rst_n mid-operation aborts any debounce or step in progress. The block restarts in MANUAL at idx 0.
- A switch held high through reset release yields one press once it has been debounced.
- Press latency: let edge 0 be the first edge sampling the new raw level.
  - The accepted level and press pulse are visible after edge DEBOUNCE_LIMIT+2.
  - The idx, o_mode or o_paused update and o_step are visible after edge DEBOUNCE_LIMIT+3.
- A raw pulse shorter than DEBOUNCE_LIMIT+1 cycles after synchronisation produces no press.
- Auto cadence: after the edge that changes mode or resumes from a cleared count, the first step occurs STEP_LIMIT+1 edges later, then every STEP_LIMIT+1 edges.
- A press1 in the same cycle as an auto step: the mode changes, the step is suppressed, and idx holds.

## Test plan
(All scenarios use DEBOUNCE_LIMIT=3, STEP_LIMIT=7.)
- Reset: hold i_rst_n low, then release. All outputs read 0 with o_mode=00. Pull i_rst_n low mid-cycle and outputs clear without waiting for a clock edge.
- Debounce: i_switch_2 high for 3 cycles -> no o_step and idx stays 0. Then hold it high for 12 cycles -> idx=1 after edge 6 with a one-cycle o_step, and no further change on release.
- Manual wrap: 4 clean presses of switch 2 -> idx sequence 1, 2, 3, 0, with one o_step per press.
- Auto up: press switch 1 -> o_mode=01. idx increments every 8 cycles (0->1->2->3->0) with an o_step pulse at each change.
- Auto down with pause: press switch 1 again -> o_mode=10 and idx decrements (e.g. 0->3).
  - Press switch 2 -> o_paused=1; idx and the step count stay frozen for 30 cycles.
  - Press switch 2 again -> resumes, and the next step occurs after the remaining count.
- Simultaneous and abort:
  - In MANUAL at idx 2, drive both switches high on the same cycle -> o_mode=01, idx stays 2.
  - In AUTO_UP, assert reset mid-count -> outputs return to their reset values and auto stepping stops.
